// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write ports, NRD combinational read ports,
// optional write-to-read bypass, and a post-reset sequential clear engine.
module reg_file_mp #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NREGS     = 32,
    parameter int unsigned     AW        = 5,
    parameter int unsigned     NRD       = 2,
    parameter int unsigned     BYPASS    = 1,
    parameter int unsigned     SP_IDX    = 2,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(32'h8000),
    parameter int unsigned     PROBE_IDX = 10,
    parameter int unsigned     PROBE_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [PROBE_W-1:0]  probe_data
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the clear engine initialises it. Port 1's later NBA wins on collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_idx] <= (clr_idx == AW'(SP_IDX)) ? SP_INIT : '0;
        end else begin
            if (we0 && (waddr0 != '0)) regs[waddr0] <= wdata0;
            if (we1 && (waddr1 != '0)) regs[waddr1] <= wdata1;
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        rdata = '0;
        a     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            a = raddr[k*AW +: AW];
            if (ready && (a != '0)) begin
                if ((BYPASS != 0) && we1 && (waddr1 == a))
                    rdata[k*XLEN +: XLEN] = wdata1;
                else if ((BYPASS != 0) && we0 && (waddr0 == a))
                    rdata[k*XLEN +: XLEN] = wdata0;
                else
                    rdata[k*XLEN +: XLEN] = regs[a];
            end
        end
    end

    assign probe_data = ready ? regs[PROBE_IDX][PROBE_W-1:0] : '0;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: clear sequence, writes, collisions,
// address-0 handling, bypass, probe, and reset during the clear sequence.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [3:0]  probe_data;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    reg_file_mp #(
        .XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1),
        .SP_IDX(2), .SP_INIT(32'h8000), .PROBE_IDX(10), .PROBE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .probe_data(probe_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        raddr = {5'd3, 5'd2};

        repeat (3) tick();
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_rdata", rdata, 64'd0);
        check("reset_probe", {60'd0, probe_data}, 64'd0);

        // Clear sequence: ready stays low for 31 edges, rises on edge 32.
        reset = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check($sformatf("clear_ready_e%0d", i), {63'd0, ready}, 64'd0);
        end
        check("clear_rdata_zero", rdata, 64'd0);
        tick();
        check("ready_e32", {63'd0, ready}, 64'd1);
        check("read_sp_and_r3", rdata, {32'h0, 32'h8000});
        raddr = {5'd31, 5'd0};
        #1 check("read_r0_r31", rdata, 64'd0);
        check("probe_after_clear", {60'd0, probe_data}, 64'd0);

        // Single write with same-cycle bypass, then stored value.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        raddr = {5'd2, 5'd5};
        #1 check("bypass_w0_r5", rdata, {32'h8000, 32'hDEADBEEF});
        tick();
        we0 = 1'b0;
        #1 check("stored_r5", rdata, {32'h8000, 32'hDEADBEEF});

        // Same-address collision: port 1 wins, also through bypass.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr = {5'd7, 5'd7};
        #1 check("bypass_collide_r7", rdata, {32'h22, 32'h22});
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1 check("stored_collide_r7", rdata, {32'h22, 32'h22});

        // Writes to register 0 are dropped on both ports.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        raddr = {5'd0, 5'd0};
        #1 check("bypass_r0_zero", rdata, 64'd0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1 check("stored_r0_zero", rdata, 64'd0);

        // Different addresses commit together.
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h1234;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h5678;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        raddr = {5'd9, 5'd8};
        #1 check("dual_commit_r8_r9", rdata, {32'h5678, 32'h1234});

        // Probe shows stored value only, no bypass.
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h0000000A;
        #1 check("probe_no_bypass", {60'd0, probe_data}, 64'd0);
        tick();
        we1 = 1'b0;
        #1 check("probe_r10", {60'd0, probe_data}, 64'hA);

        // Stale data in reg 20 before the second reset.
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hCAFE;
        tick();
        we0 = 1'b0;
        raddr = {5'd20, 5'd20};
        #1 check("stale_r20", rdata, {32'hCAFE, 32'hCAFE});

        // Reset from RUN, then again at clear cycle 10 with writes attempted throughout.
        reset = 1'b0;
        #1 check("rst_run_ready", {63'd0, ready}, 64'd0);
        check("rst_run_rdata", rdata, 64'd0);
        tick();
        reset = 1'b1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55;
        repeat (10) tick();
        reset = 1'b0;
        #1 check("rst_mid_ready", {63'd0, ready}, 64'd0);
        check("rst_mid_rdata", rdata, 64'd0);
        check("rst_mid_probe", {60'd0, probe_data}, 64'd0);
        reset = 1'b1;
        repeat (31) tick();
        check("reclear_ready_e31", {63'd0, ready}, 64'd0);
        check("reclear_rdata_zero", rdata, 64'd0);
        tick();
        we0 = 1'b0;
        #1 check("reclear_ready_e32", {63'd0, ready}, 64'd1);
        raddr = {5'd20, 5'd3};
        #1 check("reclear_r20_r3", rdata, 64'd0);
        raddr = {5'd5, 5'd2};
        #1 check("reclear_r5_sp", rdata, {32'h0, 32'h8000});
        check("reclear_probe", {60'd0, probe_data}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write/two-read file in the decode stage. Adds configurable width/depth/read-port count, a second write port (for a future dual-issue or load-return path), optional write-to-read bypass, and a sequential clear engine that initialises every register after reset. A configurable probe port carries a low slice of one register to the board debug LEDs.

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of registers (power of two, >=4)
AW, 5, address width, must equal log2(NREGS)
NRD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
SP_IDX, 2, register preloaded with SP_INIT by the clear engine
SP_INIT, 32'h8000, stack pointer initial value
PROBE_IDX, 10, register driven onto probe_data
PROBE_W, 4, probe slice width (bits [PROBE_W-1:0])

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ready  out  1  high once clear sequence is complete
we0  in  1  write enable, port 0
waddr0  in  AW  write address, port 0
wdata0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  AW  write address, port 1
wdata1  in  XLEN  write data, port 1
raddr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
rdata  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
probe_data  out  PROBE_W  low bits of register PROBE_IDX

Behaviour:
- Reset low (async): state=CLEAR, clr_idx=0, ready=0. Array contents not touched by async reset.
- FSM states CLEAR, RUN. CLEAR: each cycle write reg[clr_idx] <= (clr_idx==SP_IDX ? SP_INIT : 0), clr_idx++. When clr_idx==NREGS-1 is written, next state RUN. ready rises on the edge that writes the last register; first rising edge after reset release writes reg[0], so ready=1 after exactly NREGS edges.
- Reset asserted mid-CLEAR or in RUN: immediately back to CLEAR, clr_idx=0, sequence restarts from register 0.
- In CLEAR: we0/we1 ignored; rdata all zero; probe_data zero.
- In RUN: synchronous writes on rising edge. Writes to address 0 dropped on both ports; reg[0] reads 0 always.
- Both ports same non-zero address same cycle: port 1 wins, port 0 discarded. Different addresses: both commit.
- Reads combinational from raddr. raddr==0 -> 0.
- BYPASS=1: if a read address matches an enabled non-zero write address in the same cycle, rdata returns that write data (port 1 priority over port 0) instead of stored value. BYPASS=0: stored value; new value visible after the edge.
- probe_data = reg[PROBE_IDX][PROBE_W-1:0], stored value, no bypass.
- No out-of-range addresses possible (NREGS = 2^AW).

Test Plan:
- Release reset, hold we0=we1=0 -> ready=0 for 31 edges, ready=1 after edge 32; all reads 0 except raddr=2 -> 32'h8000.
- RUN: we0=1, waddr0=5, wdata0=32'hDEADBEEF; next cycle raddr port0=5 -> 32'hDEADBEEF; BYPASS=1 same cycle raddr=5 -> 32'hDEADBEEF before the edge.
- we0 and we1 both to addr 7 with 32'h11 / 32'h22 -> reg7 reads 32'h22; bypass read in that cycle also 32'h22.
- Write 32'hFFFFFFFF to addr 0 on both ports -> raddr=0 reads 0.
- Write 32'h0000000A to reg 10 -> probe_data=4'hA next cycle.
- Pull reset low at CLEAR cycle 10 with reg 20 holding stale data, release -> ready again after 32 edges, reg20 reads 0, writes during CLEAR (we0=1, addr 3, 32'h55) have no effect (reg3=0).
